// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall bit positions,
// stall-vector encodings, divide sequencer state encoding and control polarities.
package pipe_stall_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [5:0] STALL_NONE   = 6'b000000;
  localparam logic [5:0] STALL_ID_ENC = 6'b000111;
  localparam logic [5:0] STALL_EX_ENC = 6'b001111;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_div_seq.sv
// Multi-cycle divide sequencer: tracks busy cycles and raises the EX stall
// request until the result is ready.
//   state | meaning
//   IDLE  | no divide in flight; a start request stalls EX this cycle
//   BUSY  | divide iterating, div_count advances each cycle
//   DONE  | result valid for one cycle, EX allowed to advance
module pipe_stall_ctrl_div_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_start,
  input  logic       div_by_zero,
  input  logic       flush_req,
  output logic       busy,
  output logic       ready,
  output logic       stallreq,
  output logic [5:0] count
);

  localparam logic [5:0] LAST_COUNT = 6'(DIV_CYCLES - 1);

  div_state_e state, state_nxt;
  logic [5:0] count_nxt;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= DIV_IDLE;
      count <= 6'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    busy      = 1'b0;
    ready     = 1'b0;
    stallreq  = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (div_start && !flush_req) begin
          stallreq = 1'b1;
          if (div_by_zero) begin
            state_nxt = DIV_DONE;
          end else begin
            state_nxt = DIV_BUSY;
            count_nxt = 6'd0;
          end
        end
      end
      DIV_BUSY: begin
        busy     = 1'b1;
        stallreq = 1'b1;
        if (flush_req) begin
          state_nxt = DIV_IDLE;
          count_nxt = 6'd0;
        end else if (count == LAST_COUNT) begin
          state_nxt = DIV_DONE;
        end else begin
          count_nxt = count + 6'd1;
        end
      end
      DIV_DONE: begin
        // A start still visible here belongs to the retiring divide.
        ready     = 1'b1;
        state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
    if (rst == RST_ENABLE) begin
      busy     = 1'b0;
      ready    = 1'b0;
      stallreq = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges ID/EX/divide stall requests with flush
// priority into the stall vector, and counts stalled cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_id,
  input  logic              stallreq_from_ex,
  input  logic              div_start_i,
  input  logic              div_by_zero_i,
  input  logic              flush_req_i,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              div_busy_o,
  output logic              div_ready_o,
  output logic [5:0]        div_count_o,
  output logic [PERF_W-1:0] stall_cycles_o
);

  logic div_stallreq;

  pipe_stall_ctrl_div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start_i),
    .div_by_zero(div_by_zero_i),
    .flush_req  (flush_req_i),
    .busy       (div_busy_o),
    .ready      (div_ready_o),
    .stallreq   (div_stallreq),
    .count      (div_count_o)
  );

  always_comb begin
    stall = STALL_NONE;
    flush = 1'b0;
    if (rst == RST_ENABLE) begin
      stall = STALL_NONE;
    end else if (flush_req_i) begin
      flush = 1'b1;
    end else if (stallreq_from_ex || div_stallreq) begin
      stall = STALL_EX_ENC;
    end else if (stallreq_from_id) begin
      stall = STALL_ID_ENC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      stall_cycles_o <= '0;
    end else if (stall[STALL_PC] == STOP && stall_cycles_o != {PERF_W{1'b1}}) begin
      stall_cycles_o <= stall_cycles_o + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; a second narrow-counter instance
// exercises perf-counter saturation.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_req, ex_req, div_start, div_zero, flush_req;
  logic [5:0]  stall, stall2;
  logic        flush, flush2, busy, busy2, ready, ready2;
  logic [5:0]  dcount, dcount2;
  logic [31:0] perf;
  logic [1:0]  perf2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_from_id(id_req), .stallreq_from_ex(ex_req),
    .div_start_i(div_start), .div_by_zero_i(div_zero), .flush_req_i(flush_req),
    .stall(stall), .flush(flush), .div_busy_o(busy), .div_ready_o(ready),
    .div_count_o(dcount), .stall_cycles_o(perf)
  );

  pipe_stall_ctrl #(.DIV_CYCLES(4), .PERF_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stallreq_from_id(id_req), .stallreq_from_ex(ex_req),
    .div_start_i(div_start), .div_by_zero_i(div_zero), .flush_req_i(flush_req),
    .stall(stall2), .flush(flush2), .div_busy_o(busy2), .div_ready_o(ready2),
    .div_count_o(dcount2), .stall_cycles_o(perf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then settle just after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_req = 1'b1; ex_req = 1'b1; div_start = 1'b1; div_zero = 1'b0; flush_req = 1'b1;
    cyc(); cyc();
    #1;
    chk("rst_stall", 32'(stall), 32'h00);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_perf", perf, 32'h0);
    chk("rst_count", 32'(dcount), 32'h0);

    rst = 1'b0; id_req = 1'b0; ex_req = 1'b0; div_start = 1'b0; flush_req = 1'b0;
    #1;
    chk("idle_stall", 32'(stall), 32'h00);

    // load-use
    id_req = 1'b1;
    #1;
    chk("lu_stall", 32'(stall), 32'h07);
    chk("lu_flush", 32'(flush), 32'h0);
    cyc();
    id_req = 1'b0;
    #1;
    chk("lu_release", 32'(stall), 32'h00);
    chk("lu_perf", perf, 32'd1);
    chk("sat_perf1", 32'(perf2), 32'd1);

    // full divide, DIV_CYCLES=32
    div_start = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      id_req = (i == 5);
      #1;
      chk("div_stall", 32'(stall), 32'h0F);
      chk("div_busy", 32'(busy), (i > 0) ? 32'h1 : 32'h0);
      chk("div_count", 32'(dcount), (i > 0) ? 32'(i - 1) : 32'h0);
      chk("div_ready_low", 32'(ready), 32'h0);
      cyc();
    end
    id_req = 1'b0;
    #1;
    chk("div_done_stall", 32'(stall), 32'h00);
    chk("div_done_ready", 32'(ready), 32'h1);
    chk("div_done_busy", 32'(busy), 32'h0);
    chk("div_done_count", 32'(dcount), 32'd31);
    chk("div_perf", perf, 32'd34);
    cyc();
    div_start = 1'b0;
    #1;
    chk("div_after_stall", 32'(stall), 32'h00);
    chk("div_after_ready", 32'(ready), 32'h0);
    chk("div_count_hold", 32'(dcount), 32'd31);
    chk("sat_perf_hold", 32'(perf2), 32'd3);

    // divide by zero
    div_start = 1'b1; div_zero = 1'b1;
    #1;
    chk("dz_stall", 32'(stall), 32'h0F);
    chk("dz_busy", 32'(busy), 32'h0);
    cyc();
    div_start = 1'b0; div_zero = 1'b0;
    #1;
    chk("dz_ready", 32'(ready), 32'h1);
    chk("dz_stall_rel", 32'(stall), 32'h00);
    chk("dz_busy2", 32'(busy), 32'h0);
    cyc();
    chk("dz_ready_pulse", 32'(ready), 32'h0);
    chk("dz_perf", perf, 32'd35);

    // flush mid-divide at count 10
    div_start = 1'b1;
    for (int i = 0; i <= 10; i++) cyc();
    chk("fl_count", 32'(dcount), 32'd10);
    chk("fl_busy", 32'(busy), 32'h1);
    flush_req = 1'b1;
    #1;
    chk("fl_flush", 32'(flush), 32'h1);
    chk("fl_stall", 32'(stall), 32'h00);
    cyc();
    flush_req = 1'b0; div_start = 1'b0;
    #1;
    chk("fl_busy_after", 32'(busy), 32'h0);
    chk("fl_count_clr", 32'(dcount), 32'h0);
    chk("fl_no_ready", 32'(ready), 32'h0);
    chk("fl_perf", perf, 32'd46);

    // restart after flush begins at count 0
    div_start = 1'b1;
    #1;
    chk("rs_stall", 32'(stall), 32'h0F);
    cyc();
    chk("rs_busy", 32'(busy), 32'h1);
    chk("rs_count", 32'(dcount), 32'h0);
    cyc();
    chk("rs_count1", 32'(dcount), 32'd1);

    // reset mid-divide
    rst = 1'b1;
    #1;
    chk("rm_stall", 32'(stall), 32'h00);
    chk("rm_busy", 32'(busy), 32'h0);
    cyc();
    rst = 1'b0; div_start = 1'b0;
    #1;
    chk("rm_state", 32'(busy), 32'h0);
    chk("rm_count", 32'(dcount), 32'h0);
    chk("rm_ready", 32'(ready), 32'h0);
    chk("rm_perf", perf, 32'h0);
    chk("rm_perf_sat", 32'(perf2), 32'h0);

    // EX request priorities
    ex_req = 1'b1;
    #1;
    chk("ex_stall", 32'(stall), 32'h0F);
    id_req = 1'b1;
    #1;
    chk("ex_id_stall", 32'(stall), 32'h0F);
    flush_req = 1'b1;
    #1;
    chk("fl_all_stall", 32'(stall), 32'h00);
    chk("fl_all_flush", 32'(flush), 32'h1);
    ex_req = 1'b0; id_req = 1'b0; flush_req = 1'b0;

    // saturation: 2-bit counter stalled 5 cycles holds at 3
    id_req = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    id_req = 1'b0;
    #1;
    chk("sat_perf", 32'(perf2), 32'd3);
    chk("sat_wide_perf", perf, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
